// File: rtl/sisc_route_pkg.sv
// Shared constants for the result-routing slice.
// SEL_A / SEL_B : destination select encodings for demux32_buf.in_sel
// DATA_W        : default channel data width
// ROUTE_DEPTH   : default entries per destination FIFO
package sisc_route_pkg;

    localparam logic SEL_A       = 1'b0;
    localparam logic SEL_B       = 1'b1;
    localparam int   DATA_W      = 32;
    localparam int   ROUTE_DEPTH = 2;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy and full/empty flags.
// Ports:
//   clk, rst_f        : clock, asynchronous active-low reset
//   wr_en, wr_data    : push request and data (ignored when full)
//   rd_en, rd_data    : pop request (ignored when empty), head entry
//   full, empty       : registered status flags
//   count             : registered occupancy, 0..DEPTH
module sync_fifo
    import sisc_route_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int DEPTH = ROUTE_DEPTH,
    localparam int CW   = $clog2(DEPTH) + 1,
    localparam int PW   = CW - 1
) (
    input  logic             clk,
    input  logic             rst_f,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    count_nxt_s;
    logic             full_r;
    logic             empty_r;
    logic             do_wr_s;
    logic             do_rd_s;

    // Qualify requests with the registered flags and compute next occupancy.
    always_comb begin
        do_wr_s     = wr_en && !full_r;
        do_rd_s     = rd_en && !empty_r;
        count_nxt_s = count_r;
        case ({do_wr_s, do_rd_s})
            2'b10:   count_nxt_s = count_r + CW'(1);
            2'b01:   count_nxt_s = count_r - CW'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Storage array; cleared on reset so an empty FIFO shows zero data.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (do_wr_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Pointers (wrap naturally since DEPTH is a power of two), count and flags.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (do_wr_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (do_rd_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            count_r <= count_nxt_s;
            full_r  <= (count_nxt_s == CW'(DEPTH));
            empty_r <= (count_nxt_s == CW'(0));
        end
    end

    assign rd_data = mem_r[rd_ptr_r];
    assign full    = full_r;
    assign empty   = empty_r;
    assign count   = count_r;

endmodule

// File: rtl/demux32_buf.sv
// One-to-two result distributor: routes a producer stream to consumer A
// (in_sel=0, register-file write) or consumer B (in_sel=1, store path),
// each behind its own FIFO so a stalled consumer only blocks its own traffic.
// Ports:
//   clk, rst_f                      : clock, asynchronous active-low reset
//   in_data/in_valid/in_sel/in_ready : producer channel
//   a_data/a_valid/a_ready/a_count  : consumer A channel and FIFO occupancy
//   b_data/b_valid/b_ready/b_count  : consumer B channel and FIFO occupancy
module demux32_buf
    import sisc_route_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int DEPTH = ROUTE_DEPTH,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_f,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_sel,
    output logic             in_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [CW-1:0]    a_count,
    output logic [WIDTH-1:0] b_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [CW-1:0]    b_count
);

    logic a_full_s;
    logic a_empty_s;
    logic b_full_s;
    logic b_empty_s;
    logic in_ready_s;
    logic a_wr_s;
    logic b_wr_s;

    // Ready depends only on in_sel and the registered full flags, never on
    // the consumer readies, so a full FIFO refuses a push even while popping.
    always_comb begin
        in_ready_s = 1'b0;
        a_wr_s     = 1'b0;
        b_wr_s     = 1'b0;
        if (in_sel == SEL_B) begin
            in_ready_s = !b_full_s;
            b_wr_s     = in_valid && !b_full_s;
        end else begin
            in_ready_s = !a_full_s;
            a_wr_s     = in_valid && !a_full_s;
        end
    end

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo_a (
        .clk     (clk),
        .rst_f   (rst_f),
        .wr_en   (a_wr_s),
        .wr_data (in_data),
        .rd_en   (a_ready),
        .rd_data (a_data),
        .full    (a_full_s),
        .empty   (a_empty_s),
        .count   (a_count)
    );

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo_b (
        .clk     (clk),
        .rst_f   (rst_f),
        .wr_en   (b_wr_s),
        .wr_data (in_data),
        .rd_en   (b_ready),
        .rd_data (b_data),
        .full    (b_full_s),
        .empty   (b_empty_s),
        .count   (b_count)
    );

    assign in_ready = in_ready_s;
    assign a_valid  = !a_empty_s;
    assign b_valid  = !b_empty_s;

endmodule

// File: tb/tb_demux32_buf.sv
// Directed bench for demux32_buf with a queue-based reference model per
// destination; outputs are compared on the falling clock edge.
module tb_demux32_buf;

    localparam int W  = 32;
    localparam int D  = 2;
    localparam int CW = $clog2(D) + 1;

    logic          clk = 1'b0;
    logic          rst_f;
    logic [W-1:0]  in_data;
    logic          in_valid;
    logic          in_sel;
    logic          in_ready;
    logic [W-1:0]  a_data;
    logic          a_valid;
    logic          a_ready;
    logic [CW-1:0] a_count;
    logic [W-1:0]  b_data;
    logic          b_valid;
    logic          b_ready;
    logic [CW-1:0] b_count;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];

    always #5 clk = ~clk;

    demux32_buf #(.WIDTH(W), .DEPTH(D)) dut (
        .clk      (clk),
        .rst_f    (rst_f),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_sel   (in_sel),
        .in_ready (in_ready),
        .a_data   (a_data),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .a_count  (a_count),
        .b_data   (b_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .b_count  (b_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare against the model at negedge, then advance the model over the
    // coming rising edge and wait until just after it.
    task automatic tick();
        logic exp_ready;
        logic accept;
        @(negedge clk);
        exp_ready = in_sel ? (qb.size() < D) : (qa.size() < D);
        chk("in_ready", 32'(in_ready), 32'(exp_ready));
        chk("a_valid", 32'(a_valid), 32'(qa.size() != 0));
        chk("a_count", 32'(a_count), 32'(qa.size()));
        chk("b_valid", 32'(b_valid), 32'(qb.size() != 0));
        chk("b_count", 32'(b_count), 32'(qb.size()));
        if (qa.size() != 0) chk("a_data", a_data, qa[0]);
        if (qb.size() != 0) chk("b_data", b_data, qb[0]);
        accept = in_valid && exp_ready;
        if (a_ready && qa.size() != 0) void'(qa.pop_front());
        if (b_ready && qb.size() != 0) void'(qb.pop_front());
        if (accept) begin
            if (in_sel) qb.push_back(in_data);
            else        qa.push_back(in_data);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic sel, input logic [W-1:0] d);
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid = 1'b0;
        a_ready  = 1'b1;
        b_ready  = 1'b1;
        for (int i = 0; i < 3; i++) tick();
    endtask

    initial begin
        rst_f    = 1'b0;
        in_data  = '0;
        in_valid = 1'b0;
        in_sel   = 1'b0;
        a_ready  = 1'b0;
        b_ready  = 1'b0;
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_a_valid", 32'(a_valid), 32'd0);
        chk("rst_b_valid", 32'(b_valid), 32'd0);
        chk("rst_a_data", a_data, 32'd0);
        chk("rst_b_data", b_data, 32'd0);
        chk("rst_a_count", 32'(a_count), 32'd0);
        rst_f = 1'b1;
        @(posedge clk);
        #1;

        // Basic route
        a_ready = 1'b1;
        b_ready = 1'b1;
        push(1'b0, 32'h0000_00AA);
        chk("route_a_data", a_data, 32'h0000_00AA);
        chk("route_a_valid", 32'(a_valid), 32'd1);
        push(1'b1, 32'h0000_00BB);
        chk("route_b_data", b_data, 32'h0000_00BB);
        chk("route_a_gone", 32'(a_valid), 32'd0);
        drain();

        // Backpressure: third push stalls until the first pop
        a_ready = 1'b0;
        push(1'b0, 32'h1);
        push(1'b0, 32'h2);
        in_valid = 1'b1;
        in_sel   = 1'b0;
        in_data  = 32'h3;
        #1;
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_a_count", 32'(a_count), 32'd2);
        tick();
        a_ready = 1'b1;
        tick();
        chk("bp_still_stalled_cnt", 32'(a_count), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("bp_third_head", a_data, 32'h3);
        drain();

        // Isolation: A full and stalled, B still accepts
        a_ready = 1'b0;
        b_ready = 1'b0;
        push(1'b0, 32'h11);
        push(1'b0, 32'h22);
        in_valid = 1'b1;
        in_sel   = 1'b1;
        in_data  = 32'h0000_C0DE;
        #1;
        chk("iso_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("iso_b_data", b_data, 32'h0000_C0DE);
        chk("iso_a_head", a_data, 32'h11);
        chk("iso_a_count", 32'(a_count), 32'd2);
        tick();
        drain();

        // Reset mid-stream with two entries in A
        a_ready = 1'b0;
        push(1'b0, 32'h55);
        push(1'b0, 32'h66);
        rst_f = 1'b0;
        #1;
        chk("mrst_a_valid", 32'(a_valid), 32'd0);
        chk("mrst_a_count", 32'(a_count), 32'd0);
        chk("mrst_in_ready", 32'(in_ready), 32'd1);
        chk("mrst_a_data", a_data, 32'd0);
        qa.delete();
        qb.delete();
        #1;
        rst_f = 1'b1;
        @(posedge clk);
        #1;
        tick();

        // Simultaneous push and pop on A
        a_ready = 1'b0;
        push(1'b0, 32'hAAAA_0001);
        a_ready = 1'b1;
        push(1'b0, 32'hAAAA_0002);
        chk("pp_a_count", 32'(a_count), 32'd1);
        chk("pp_a_head", a_data, 32'hAAAA_0002);
        drain();

        // Wrap: ten back-to-back pushes to B
        b_ready = 1'b1;
        in_sel  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = W'(i);
            tick();
        end
        in_valid = 1'b0;
        drain();

        // Random mixed traffic with occasional stalls on both sides
        for (int i = 0; i < 60; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_sel   = 1'($urandom_range(0, 1));
            in_data  = $urandom;
            a_ready  = 1'($urandom_range(0, 1));
            b_ready  = 1'($urandom_range(0, 1));
            tick();
            if (in_valid && !in_ready) begin
                // hold data/sel stable while stalled
                a_ready = 1'b1;
                b_ready = 1'b1;
                tick();
            end
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/demux32_buf.md
Name: demux32_buf

Overview:
- One-to-two result distributor: the opposite direction of the 32-bit writeback select mux. It routes a single 32-bit producer stream to one of two consumers.
- Port A (sel=0) typically feeds the register file write port. Port B (sel=1) feeds the data-memory store path.
- Each destination has its own small synchronous FIFO, so a stalled consumer blocks only traffic selected to it.
- Valid/ready handshake on all three channels.

Parameters:
WIDTH, 32, data width of all channels
DEPTH, 2, entries per destination FIFO; power of two, >= 2
CW, $clog2(DEPTH)+1, occupancy counter width (derived, not overridden)

Ports:
clk  input  1  system clock, rising edge
rst_f  input  1  asynchronous active-low reset
in_data  input  WIDTH  producer data
in_valid  input  1  producer data valid
in_sel  input  1  destination select: 0 -> A, 1 -> B; sampled with in_data
in_ready  output  1  selected destination can accept
a_data  output  WIDTH  head entry of FIFO A
a_valid  output  1  FIFO A non-empty
a_ready  input  1  consumer A accepts
a_count  output  CW  FIFO A occupancy
b_data  output  WIDTH  head entry of FIFO B
b_valid  output  1  FIFO B non-empty
b_ready  input  1  consumer B accepts
b_count  output  CW  FIFO B occupancy

Behaviour:
- Reset (rst_f=0, asynchronous, immediate):
  - All FIFO pointers, counts and storage clear to 0.
  - a_valid=b_valid=0, a_data=b_data=0, a_count=b_count=0.
  - in_ready=1, since both FIFOs are empty and not full.
- Reset asserted mid-operation flushes all buffered entries. No entry survives.
- Release takes effect on the first clk edge after rst_f goes high.
- Push:
  - in_ready = in_sel ? !b_full : !a_full. This is combinational from in_sel and the registered full flags only.
  - No combinational path exists from a_ready/b_ready to in_ready.
  - A transfer occurs when in_valid && in_ready at a rising edge. The data is written into the FIFO chosen by in_sel; the other FIFO is untouched.
  - in_data and in_sel must be held stable while in_valid=1 and in_ready=0.
- Pop:
  - Consumer X takes the head entry when x_valid && x_ready at a rising edge. The read pointer advances.
  - x_ready while x_valid=0 has no effect.
- Latency: a push into an empty FIFO is visible on x_valid/x_data the cycle after acceptance. There is no input-to-output combinational bypass.
- Output data:
  - x_data is the head entry. It is held stable while x_valid=1 and x_ready=0.
  - When the FIFO is empty, x_data shows the stale storage slot. It is 0 after reset.
- Occupancy:
  - Push only: x_count+1.
  - Pop only: x_count-1.
  - Push and pop same cycle: unchanged.
  - full = (count==DEPTH); empty = (count==0).
- Full FIFO with simultaneous pop: in_ready stays 0 that cycle, so no push occurs. This is a deliberate choice to keep ready registered-only.
- Pointers are CW-1 bits wide and wrap modulo DEPTH. There are no illegal states.
- The two FIFOs are fully independent. A can push while B pops, and both can pop in the same cycle.
- Ordering: order is preserved per destination. No ordering relation exists between A and B.

Decomposition:
- Package sisc_route_pkg holds:
  - constants SEL_A=1'b0, SEL_B=1'b1
  - default DATA_W=32 and ROUTE_DEPTH=2
- Sub-module sync_fifo (params WIDTH, DEPTH; ports clk, rst_f, wr_en, wr_data, rd_en, rd_data, full, empty, count):
  - instantiated twice, as u_fifo_a and u_fifo_b
  - top level contains only the select/ready steering and the wr_en gating

Test Plan:
- Reset: drive rst_f=0 mid-stream with 2 entries in A -> a_valid=0, a_count=0, in_ready=1 immediately, before any clk edge.
- Basic route: push 0x0000_00AA with sel=0, then 0x0000_00BB with sel=1, a_ready=b_ready=1 -> a_data=0xAA and b_data=0xBB, each valid for one cycle, one cycle after their push.
- Backpressure: a_ready=0, push 0x1, 0x2, 0x3 with sel=0 (DEPTH=2) -> the third push stalls with in_ready=0 and a_count=2. Then raise a_ready -> pops 0x1, 0x2; 0x3 enters the cycle after the first pop.
- Isolation: A full with a_ready=0, push 0xC0DE with sel=1 -> in_ready=1, accepted, b_data=0xC0DE next cycle; A contents unchanged.
- Simultaneous push/pop: A holds one entry, push with sel=0 and a_ready=1 in the same cycle -> a_count stays 1, the next head is the new word, and order is preserved.
- Wrap: 10 back-to-back pushes 0..9 to B with b_ready=1 -> b_data sequence 0..9 in order, no loss or duplication, b_count never exceeds 2.
